bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares the single CPU-side BRAM port B (32-bit words, 4 byte-write enables, 15-bit word address) between two requesters: requester 0 is the CPU load/store path (already lane-aligned data and byte enables) and requester 1 is the buffer DMA engine.
- Fixed priority to the CPU, with a starvation counter that forces one DMA grant after a bounded wait.
- Registers the BRAM command, tracks read latency, and routes read data back to the requester that issued it, tagged by owner.

Parameters:
- ADDR_W, 15, word address width to BRAM.
- RD_LAT, 1, BRAM read latency in cycles from registered enable to valid dout; legal values 1..4.
- STARVE_LIMIT, 8, consecutive cycles DMA may be denied before it receives forced priority; legal values 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU command valid.
- cpu_we  in  4  CPU byte write enables; 0000 means read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  32  CPU write data, lane-aligned.
- cpu_gnt  out  1  CPU command accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid.
- dma_req  in  1  DMA command valid.
- dma_we  in  4  DMA byte write enables; 0000 means read.
- dma_addr  in  ADDR_W  DMA word address.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  DMA command accepted this cycle (combinational).
- dma_rvalid  out  1  DMA read data valid.
- rdata  out  32  read data, shared; qualified by cpu_rvalid or dma_rvalid.
- enaB  out  1  BRAM port enable (registered).
- weB  out  4  BRAM byte write enables (registered).
- addrB  out  ADDR_W  BRAM address (registered).
- dinToMem  out  32  BRAM write data (registered).
- doutB  in  32  BRAM read data.
- starve_cnt  out  8  debug: current DMA wait count.

Behaviour:
- Handshake: a command is accepted in cycle N when req && gnt. A requester holds req and all command fields stable until granted. gnt depends only on the req inputs and the internal state, never on addr or data.
- Arbitration:
  - Only cpu_req: CPU granted.
  - Only dma_req: DMA granted.
  - Both, with starve_cnt < STARVE_LIMIT: CPU granted.
  - Both, with starve_cnt == STARVE_LIMIT: DMA granted.
  - At most one gnt is high in any cycle. No gnt when there is no req.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on every cycle dma_req is high and dma_gnt is low.
  - Clears to 0 on a DMA grant.
  - Holds when dma_req is low.
- Issue: the accepted command is registered onto enaB/weB/addrB/dinToMem in cycle N+1. With no accept, enaB=0 and weB=0000; addrB and dinToMem hold their previous values. Throughput is one command per cycle, back-to-back, with no bubbles.
- Read tracking:
  - A read is a command with we==0000. Its owner tag (CPU/DMA) and a valid bit enter a RD_LAT+1 deep shift pipeline at accept.
  - The selected rvalid pulses in cycle N+1+RD_LAT, with rdata=doutB in the same cycle.
  - Writes produce no rvalid.
  - Reads complete in issue order; interleaved owners are each routed correctly.
- Partial writes (we of 0001..1110) pass through unchanged. The arbiter does no lane steering.
- Read-after-write to the same address from different requesters is ordered by grant order; BRAM semantics apply.
- Reset (synchronous, any cycle, including mid-read):
  - enaB=0, weB=0000, addrB=0, dinToMem=0.
  - starve_cnt=0.
  - Read pipeline cleared; in-flight reads are dropped with no rvalid.
  - cpu_rvalid=0, dma_rvalid=0, rdata=0.
  - cpu_gnt and dma_gnt are 0 while reset is high.
- rdata is 0 in any cycle with no rvalid.

Test Plan:
- Lone CPU write: cpu_req, we=1111, addr=0x0010, wdata=0xA5A5_0001 at cycle 0 → cpu_gnt at cycle 0; at cycle 1 enaB=1, weB=1111, addrB=0x0010, dinToMem=0xA5A5_0001; no rvalid.
- Read latency (RD_LAT=1): after that write, DMA reads addr 0x0010 at cycle 3 → dma_gnt at cycle 3, enaB at cycle 4, dma_rvalid=1 with rdata=0xA5A5_0001 at cycle 5; cpu_rvalid stays 0.
- Starvation: cpu_req held continuously, dma_req raised at cycle 0, STARVE_LIMIT=8 → CPU granted cycles 0–7, starve_cnt reaches 8, dma_gnt at cycle 8, starve_cnt back to 0 at cycle 9, CPU granted again from cycle 9.
- Interleaved reads: CPU read 0x0001 at cycle 0, DMA read 0x0002 at cycle 1, CPU read 0x0003 at cycle 2 → rvalids at cycles 2, 3, 4 go to CPU, DMA, CPU respectively, each with the matching BRAM data; no bubble on enaB.
- Reset mid-read: CPU read accepted at cycle 0, reset high at cycle 1 → no cpu_rvalid at cycle 2; all outputs at their reset values in cycle 2; starve_cnt=0.
- Idle/partial: DMA write we=0100, wdata=0x00AB_0000 → weB=0100 and dinToMem=0x00AB_0000 passed through unmodified; with both req low, enaB=0 every cycle.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one BRAM port between the CPU load/store path and the buffer DMA
// engine. The CPU has fixed priority, and a starvation counter forces one
// DMA grant after a bounded wait. The accepted command is registered onto
// the BRAM pins, and read data is routed back to the requester that issued
// the read, using an owner tag that travels alongside the BRAM read latency.
module bram_port_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  // CPU requester
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  // DMA requester
  input  logic              dma_req,
  input  logic [3:0]        dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  // shared read data
  output logic [31:0]       rdata,
  // BRAM port B
  output logic              enaB,
  output logic [3:0]        weB,
  output logic [ADDR_W-1:0] addrB,
  output logic [31:0]       dinToMem,
  input  logic [31:0]       doutB,
  // debug
  output logic [7:0]        starve_cnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e own;
  } rd_tag_t;

  // Starvation state
  logic [7:0]        starve_q, starve_d;
  logic              starve_hit;

  // Selected command
  logic              accept;
  logic [3:0]        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  owner_e            sel_own;
  rd_tag_t           tag_in;

  // Registered BRAM command
  logic              ena_q;
  logic [3:0]        we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;

  // Read owner pipeline: stage k is valid in cycle N+1+k after the accept
  rd_tag_t [RD_LAT:0] pipe_q;
  rd_tag_t            rd_head;
  logic               rv;

  assign starve_hit = (starve_q == LIMIT);

  // Grant decision: CPU wins a conflict unless DMA has waited LIMIT cycles
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (cpu_req && !(dma_req && starve_hit)) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  // Command mux selecting the granted requester's fields
  always_comb begin
    accept    = cpu_gnt | dma_gnt;
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    sel_own   = OWN_CPU;
    if (dma_gnt) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
      sel_own   = OWN_DMA;
    end
    tag_in.vld = accept && (sel_we == 4'b0000);
    tag_in.own = sel_own;
  end

  // Starvation counter next state: clear on DMA grant, saturate while denied
  always_comb begin
    starve_d = starve_q;
    if (dma_gnt) begin
      starve_d = '0;
    end else if (dma_req && !starve_hit) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // BRAM command register; address and data hold when nothing is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      ena_q  <= 1'b0;
      we_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      ena_q <= accept;
      we_q  <= accept ? sel_we : 4'b0000;
      if (accept) begin
        addr_q <= sel_addr;
        din_q  <= sel_wdata;
      end
    end
  end

  // Read owner shift pipeline; a reset drops every in-flight read
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Read return routing; rdata is forced to zero when no read returns
  always_comb begin
    rd_head    = pipe_q[RD_LAT];
    rv         = rd_head.vld && !reset;
    cpu_rvalid = rv && (rd_head.own == OWN_CPU);
    dma_rvalid = rv && (rd_head.own == OWN_DMA);
    rdata      = rv ? doutB : '0;
  end

  assign enaB       = ena_q;
  assign weB        = we_q;
  assign addrB      = addr_q;
  assign dinToMem   = din_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level reference model
// (grant rule, starvation count, expected read returns kept in a queue).
module tb_bram_port_arbiter;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned LIMIT  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, dma_req;
  logic [3:0]        cpu_we, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [31:0]       cpu_wdata, dma_wdata;
  logic              cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
  logic [31:0]       rdata;
  logic              enaB;
  logic [3:0]        weB;
  logic [ADDR_W-1:0] addrB;
  logic [31:0]       dinToMem;
  logic [31:0]       doutB;
  logic [7:0]        starve_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  bram_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .RD_LAT      (RD_LAT),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rvalid(dma_rvalid),
    .rdata     (rdata),
    .enaB      (enaB),
    .weB       (weB),
    .addrB     (addrB),
    .dinToMem  (dinToMem),
    .doutB     (doutB),
    .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  // BRAM behavioural model with RD_LAT cycles of read latency; non-read
  // cycles load garbage so a mistimed rvalid shows up as bad data
  logic [31:0] bmem [0:(1<<ADDR_W)-1];
  logic [31:0] dpipe [RD_LAT];
  assign doutB = dpipe[RD_LAT-1];

  always @(posedge clk) begin
    if (enaB && weB != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (weB[b]) bmem[addrB][8*b +: 8] <= dinToMem[8*b +: 8];
    end
    if (enaB && weB == 4'b0000) dpipe[0] <= bmem[addrB];
    else                        dpipe[0] <= $urandom;
    for (int i = 1; i < int'(RD_LAT); i++) dpipe[i] <= dpipe[i-1];
  end

  // Reference model state
  typedef struct {
    int unsigned cyc;
    bit          to_dma;
    logic [31:0] data;
  } rexp_t;

  logic [31:0]       refmem [0:(1<<ADDR_W)-1];
  rexp_t             rq[$];
  int unsigned       cyc = 0;
  int unsigned       m_starve = 0;
  logic              m_en = 1'b0;
  logic [3:0]        m_we = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_din = '0;
  bit                m_cpu_acc, m_dma_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, advance the
  // model, then move to just after the next rising edge for new stimulus.
  task automatic step();
    bit          ecg, edg, ecv, edv;
    logic [31:0] erd;
    logic [3:0]  we;
    logic [ADDR_W-1:0] a;
    logic [31:0] wd;
    @(negedge clk);
    ecg = 1'b0;
    edg = 1'b0;
    if (!reset) begin
      if (cpu_req && dma_req) begin
        if (m_starve == LIMIT) edg = 1'b1;
        else                   ecg = 1'b1;
      end else begin
        ecg = cpu_req;
        edg = dma_req;
      end
    end
    chk("cpu_gnt", 32'(cpu_gnt), 32'(ecg));
    chk("dma_gnt", 32'(dma_gnt), 32'(edg));
    chk("starve_cnt", 32'(starve_cnt), m_starve);
    chk("enaB", 32'(enaB), 32'(m_en));
    chk("weB", 32'(weB), 32'(m_we));
    chk("addrB", 32'(addrB), 32'(m_addr));
    chk("dinToMem", dinToMem, m_din);
    ecv = 1'b0;
    edv = 1'b0;
    erd = '0;
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      rexp_t e = rq.pop_front();
      if (!reset) begin
        ecv = !e.to_dma;
        edv = e.to_dma;
        erd = e.data;
      end
    end
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ecv));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(edv));
    chk("rdata", rdata, erd);
    m_cpu_acc = ecg;
    m_dma_acc = edg;
    if (reset) begin
      rq.delete();
      m_starve = 0;
      m_en = 1'b0;
      m_we = '0;
      m_addr = '0;
      m_din = '0;
    end else begin
      if (ecg || edg) begin
        we = edg ? dma_we : cpu_we;
        a  = edg ? dma_addr : cpu_addr;
        wd = edg ? dma_wdata : cpu_wdata;
        m_en = 1'b1;
        m_we = we;
        m_addr = a;
        m_din = wd;
        if (we == 4'b0000) begin
          rq.push_back('{cyc: cyc + 1 + RD_LAT, to_dma: edg, data: refmem[a]});
        end else begin
          for (int b = 0; b < 4; b++)
            if (we[b]) refmem[a][8*b +: 8] = wd[8*b +: 8];
        end
      end else begin
        m_en = 1'b0;
        m_we = '0;
      end
      if (edg)                               m_starve = 0;
      else if (dma_req && m_starve < LIMIT)  m_starve++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic [3:0] w, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic r, input logic [3:0] w, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
  endtask

  int unsigned n;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      bmem[i]   = '0;
      refmem[i] = '0;
    end
    for (int i = 0; i < int'(RD_LAT); i++) dpipe[i] = '0;
    reset = 1'b1;
    set_cpu(1'b0, '0, '0, '0);
    set_dma(1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;
    step();

    // Lone CPU write
    set_cpu(1'b1, 4'b1111, 15'h0010, 32'hA5A5_0001);
    step();
    chk("w_gnt_taken", 32'(m_cpu_acc), 32'd1);
    set_cpu(1'b0, '0, '0, '0);
    chk("w_enaB", 32'(enaB), 32'd1);
    chk("w_addrB", 32'(addrB), 32'h10);
    chk("w_din", dinToMem, 32'hA5A5_0001);
    step();
    step();

    // DMA read-back with latency measurement
    set_dma(1'b1, 4'b0000, 15'h0010, '0);
    step();
    set_dma(1'b0, '0, '0, '0);
    n = 1;
    while (!dma_rvalid && n < 10) begin
      step();
      n++;
    end
    chk("rd_latency", n, 1 + RD_LAT);
    chk("rd_data", rdata, 32'hA5A5_0001);
    chk("rd_cpu_quiet", 32'(cpu_rvalid), 32'd0);
    step();

    // Starvation: CPU saturates the port, DMA must win after LIMIT cycles
    set_dma(1'b1, 4'b0000, 15'h0003, '0);
    n = 0;
    while (n < 20) begin
      set_cpu(1'b1, 4'b1111, 15'(16 + n), 32'hC000_0000 + n);
      step();
      if (m_dma_acc) break;
      n++;
    end
    chk("starve_grant_cycle", n, LIMIT);
    set_dma(1'b0, '0, '0, '0);
    step();
    chk("starve_cleared", 32'(starve_cnt), 32'd0);
    set_cpu(1'b0, '0, '0, '0);
    step();

    // Interleaved reads, back to back
    set_cpu(1'b1, 4'b0000, 15'h0001, '0);
    step();
    set_cpu(1'b0, '0, '0, '0);
    set_dma(1'b1, 4'b0000, 15'h0002, '0);
    step();
    set_dma(1'b0, '0, '0, '0);
    set_cpu(1'b1, 4'b0000, 15'h0003, '0);
    step();
    set_cpu(1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) step();

    // Reset while a read is in flight
    set_cpu(1'b1, 4'b0000, 15'h0010, '0);
    step();
    set_cpu(1'b0, '0, '0, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_no_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_enaB", 32'(enaB), 32'd0);
    chk("rst_addrB", 32'(addrB), 32'd0);
    step();
    step();

    // Partial DMA write passes through unchanged, then idle
    set_dma(1'b1, 4'b0100, 15'h0005, 32'h00AB_0000);
    step();
    set_dma(1'b0, '0, '0, '0);
    chk("pw_weB", 32'(weB), 32'h4);
    chk("pw_din", dinToMem, 32'h00AB_0000);
    for (int i = 0; i < 5; i++) step();

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (m_cpu_acc) cpu_req = 1'b0;
      if (m_dma_acc) dma_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 99) < 75)
        set_cpu(1'b1, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom),
                15'($urandom_range(0, 31)), $urandom);
      if (!dma_req && $urandom_range(0, 99) < 40)
        set_dma(1'b1, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom),
                15'($urandom_range(0, 31)), $urandom);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    set_cpu(1'b0, '0, '0, '0);
    set_dma(1'b0, '0, '0, '0);
    for (int i = 0; i < 6; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
